uart_tx_baud: RTL and testbench
===============================

// Module: uart_tx_baud
// PURPOSE
//  UART transmitter, 8N1 by default; consumer of the baud_clk square wave from baud_rate_clk_gen.
//  Serialises one parallel byte per request onto the tx line, LSB first: start bit, data bits, stop bit(s).
//  Bit boundaries come from the rising edges of baud_clk, detected internally in the clk domain.
//  Sits between the user-side byte source (e.g. result dump logic) and the FPGA TX pin.
// PARAMETERS
//  DATA_BIT  8  number of data bits per frame (1..8 supported)
//  STOP_BIT  1  number of stop bits (1 or 2)
//  IDX_BIT   3  width of the internal bit index; must satisfy 2**IDX_BIT >= DATA_BIT
// PORTS
//  clk       in   1         system clock, same clock that drives baud_rate_clk_gen
//  rst       in   1         asynchronous, active-low reset (0 = reset)
//  baud_clk  in   1         baud square wave; each rising edge marks one bit period
//  tx_start  in   1         request: send tx_data; sampled only in IDLE
//  tx_data   in   DATA_BIT  byte to send; captured on the clk edge that accepts tx_start
//  tx        out  1         serial line, idle high
//  busy      out  1         high from acceptance until frame end, inclusive of the stop bit(s)
//  done      out  1         one-clk pulse at frame completion
// BEHAVIOUR
//  Reset (rst=0, async): tx=1, busy=0, done=0, state=IDLE, bit_idx=0, shift reg=0, baud_clk_d=0.
//  Tick detection:
//   - baud_tick = baud_clk & ~baud_clk_d, where baud_clk_d is baud_clk registered on clk.
//   - Exactly one clk-wide tick per baud period; all bit transitions happen only on a tick.
//  States:
//   - IDLE:  tx=1, busy=0. If tx_start=1, latch tx_data, set busy=1 on the next clk, go to ARM.
//   - ARM:   wait for baud_tick. On the tick: tx<=0, go to START. Start bit is aligned to the baud grid.
//   - START: on baud_tick: tx<=data[0], bit_idx<=0, go to DATA.
//   - DATA:  on baud_tick:
//            - if bit_idx<DATA_BIT-1: bit_idx++, tx<=data[bit_idx+1].
//            - otherwise: tx<=1, stop counter<=0, go to STOP.
//   - STOP:  on baud_tick:
//            - if stop counter<STOP_BIT-1: increment it, stay in STOP.
//            - otherwise: done<=1 for one clk, busy<=0, go to IDLE.
//  Latency:
//   - Acceptance to start bit: 1 clk to ARM, then up to one baud period waiting for the next tick.
//   - Start bit to done: exactly (1+DATA_BIT+STOP_BIT) baud periods.
//  Handshake:
//   - tx_start while busy=1 is ignored, with no queueing.
//   - tx_data may change freely after the accepting edge.
//   - tx_start held high continuously sends back-to-back frames. Re-acceptance occurs in the IDLE clk after done.
//  tx is registered, with no combinational path from inputs. done and busy=0 assert on the same clk edge.
//  Reset mid-frame: tx returns to 1 immediately (async); the partial frame is abandoned and no done pulse is produced.
//  baud_clk stuck at 0 or 1: no ticks, so the FSM holds its state indefinitely. This is legal and not an error.
// TESTING
//  Bench: baud_rate_clk_gen with BAUD_CNT=16, BAUD_BIT=5 drives baud_clk, so one tick every 16 clk.
//  T1 reset: rst=0 mid-run -> tx=1, busy=0, done=0 within the same cycle; no activity until tx_start.
//  T2 single byte: tx_data=8'hA5, tx_start pulsed 1 clk -> tx sequence per tick 0,1,0,1,0,0,1,0,1,1.
//     Each level held 16 clk; done pulses once, 160 clk after the start-bit edge.
//  T3 busy ignore: second tx_start with 8'h3C in the middle of the 8'hA5 frame -> only the A5 frame is sent; one done.
//  T4 back-to-back: tx_start held high, tx_data=8'h00 then 8'hFF -> two frames with no gap beyond one ARM wait.
//     Decoded bytes are 00 and FF; two done pulses.
//  T5 abort: rst=0 during data bit 3 -> tx=1 at once; no done.
//     The next request (8'h55) is sent correctly: 0,1,0,1,0,1,0,1,0,1.
//  T6 STOP_BIT=2, 8'h81 -> line 0,1,0,0,0,0,0,0,1,1,1 (stop held 32 clk); done after 176 clk from the start bit.

Source files
------------

// File: rtl/uart_tx_baud.sv
// UART transmitter paced by an external baud square wave.
// Sends start bit, DATA_BIT data bits LSB first, then STOP_BIT stop bits.
module uart_tx_baud #(
  parameter int DATA_BIT = 8,
  parameter int STOP_BIT = 1,
  parameter int IDX_BIT  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                baud_clk,
  input  logic                tx_start,
  input  logic [DATA_BIT-1:0] tx_data,
  output logic                tx,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [IDX_BIT-1:0] LAST_IDX = IDX_BIT'(DATA_BIT - 1);
  localparam logic LAST_STP = 1'(STOP_BIT - 1);

  state_t state_q, state_d;
  logic [IDX_BIT-1:0] idx_q, idx_d;
  logic [DATA_BIT-1:0] sh_q, sh_d, sh_nxt;
  logic stp_q, stp_d;
  logic tx_q, tx_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic bclk_q;
  logic tick;

  assign tick   = baud_clk & ~bclk_q;
  assign sh_nxt = sh_q >> 1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    stp_d   = stp_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          sh_d    = tx_data;
          busy_d  = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        if (tick) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          tx_d    = sh_q[0];
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q < LAST_IDX) begin
            idx_d = idx_q + 1'b1;
            sh_d  = sh_nxt;
            tx_d  = sh_nxt[0];
          end else begin
            tx_d    = 1'b1;
            stp_d   = 1'b0;
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (stp_q < LAST_STP) begin
            stp_d = stp_q + 1'b1;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sh_q    <= '0;
      stp_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      stp_q   <= stp_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bclk_q  <= baud_clk;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_baud.sv
// Scoreboard bench for uart_tx_baud: two instances (1 and 2 stop bits)
// share stimulus; a line decoder per instance checks frames and timing.
module tb_uart_tx_baud;

  logic clk = 1'b0;
  logic rst;
  logic baud_clk = 1'b0;
  logic [3:0] bcnt = 4'd0;
  logic tx_start;
  logic [7:0] tx_data;
  logic [1:0] tx_w, busy_w, done_w;

  int checks = 0;
  int failures = 0;
  int exp_done = 0;
  int dcnt0 = 0;
  int dcnt1 = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  // 16-clk baud square wave, one rising edge per period
  always @(posedge clk) begin
    bcnt <= bcnt + 4'd1;
    baud_clk <= bcnt[3];
  end

  uart_tx_baud #(.DATA_BIT(8), .STOP_BIT(1), .IDX_BIT(3)) dut1 (
    .clk(clk), .rst(rst), .baud_clk(baud_clk),
    .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  uart_tx_baud #(.DATA_BIT(8), .STOP_BIT(2), .IDX_BIT(3)) dut2 (
    .clk(clk), .rst(rst), .baud_clk(baud_clk),
    .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  always @(negedge clk) begin
    if (done_w[0] === 1'b1) dcnt0 <= dcnt0 + 1;
    if (done_w[1] === 1'b1) dcnt1 <= dcnt1 + 1;
  end

  task automatic chk(input int d, input string nm,
                     input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL dut%0d %s: got %0h expected %0h", d, nm, act, exp);
    end
  endtask

  task automatic mon(input int d);
    int s, n;
    bit ok_stable, ok_busy, aborted, framing;
    logic bv [0:15];
    logic [7:0] b, e;
    s = (d == 0) ? 1 : 2;
    n = (9 + s) * 16;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx_w[d] === 1'b0) begin
        aborted = 0;
        ok_stable = 1;
        ok_busy = 1;
        for (int c = 0; c <= n; c++) begin
          if (c > 0) @(negedge clk);
          if (rst !== 1'b1) begin
            aborted = 1;
            break;
          end
          if (c < n) begin
            if (c % 16 == 0) bv[c/16] = tx_w[d];
            else if (tx_w[d] !== bv[c/16]) ok_stable = 0;
            if (busy_w[d] !== 1'b1 || done_w[d] !== 1'b0) ok_busy = 0;
          end
        end
        if (!aborted) begin
          chk(d, "line_stable", int'(ok_stable), 1);
          chk(d, "busy_window", int'(ok_busy), 1);
          chk(d, "done_timing", int'({busy_w[d], done_w[d]}), 1);
          framing = (bv[0] === 1'b0) && (bv[9] === 1'b1) &&
                    (s == 1 || bv[10] === 1'b1);
          chk(d, "framing", int'(framing), 1);
          for (int i = 0; i < 8; i++) b[i] = bv[i+1];
          if (d == 0 && q0.size() > 0) begin
            e = q0.pop_front();
            chk(d, "frame_byte", int'(b), int'(e));
          end else if (d == 1 && q1.size() > 0) begin
            e = q1.pop_front();
            chk(d, "frame_byte", int'(b), int'(e));
          end else begin
            chk(d, "unexpected_frame", int'(b), -1);
          end
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  task automatic send(input logic [7:0] v, input bit ok);
    @(negedge clk);
    tx_data = v;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data = 8'($urandom);
    if (ok) begin
      q0.push_back(v);
      q1.push_back(v);
      exp_done++;
    end
  endtask

  task automatic reset_check();
    for (int d = 0; d < 2; d++) begin
      chk(d, "reset_tx", int'(tx_w[d]), 1);
      chk(d, "reset_busy", int'(busy_w[d]), 0);
      chk(d, "reset_done", int'(done_w[d]), 0);
    end
  endtask

  task automatic abort_frame();
    void'(q0.pop_back());
    void'(q1.pop_back());
    exp_done--;
    @(posedge clk);
    #2 rst = 1'b0;
    #1 reset_check();
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic done_check(input string nm);
    chk(0, nm, dcnt0, exp_done);
    chk(1, nm, dcnt1, exp_done);
  endtask

  initial begin
    int w;
    rst = 1'b1;
    tx_start = 1'b0;
    tx_data = 8'h00;
    #3 rst = 1'b0;
    #1 reset_check();
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    repeat (40) @(negedge clk);
    chk(0, "idle_tx", int'(tx_w[0]), 1);
    chk(1, "idle_busy", int'(busy_w[1]), 0);

    send(8'hA5, 1);
    repeat (210) @(negedge clk);
    done_check("done_count_single");

    send(8'hA5, 1);
    repeat (60) @(negedge clk);
    send(8'h3C, 0);
    repeat (160) @(negedge clk);
    done_check("done_count_ignore");

    @(negedge clk);
    tx_data = 8'h00;
    tx_start = 1'b1;
    q0.push_back(8'h00);
    q1.push_back(8'h00);
    q0.push_back(8'hFF);
    q1.push_back(8'hFF);
    exp_done += 2;
    repeat (5) @(negedge clk);
    tx_data = 8'hFF;
    repeat (245) @(negedge clk);
    tx_start = 1'b0;
    repeat (400) @(negedge clk);
    done_check("done_count_b2b");

    send(8'hC3, 1);
    repeat (89) @(negedge clk);
    abort_frame();
    repeat (10) @(negedge clk);
    chk(0, "post_abort_idle", int'(tx_w[0]), 1);
    send(8'h55, 1);
    repeat (210) @(negedge clk);
    done_check("done_count_abort");

    send(8'h81, 1);
    repeat (210) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      send(8'($urandom), 1);
      w = $urandom_range(20, 140);
      repeat (w) @(negedge clk);
      if ($urandom_range(0, 1) == 1) send(8'($urandom), 0);
      repeat (210 - w + $urandom_range(0, 30)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    done_check("done_count_final");
    chk(0, "queue_drained", q0.size(), 0);
    chk(1, "queue_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
